// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and the bubble encoding.
// Field indices are fixed, so any control bundle must be at least CTRL_W bits wide.
package pipe_pkg;

    localparam int CTRL_W    = 10;

    localparam int REGWRITE  = 0;
    localparam int MEMTOREG  = 1;
    localparam int MEMWRITE  = 2;
    localparam int ALUSRC    = 3;
    localparam int REGDST    = 4;
    localparam int BRANCH    = 5;
    localparam int ALUCTL_LO = 6;
    localparam int ALUCTL_HI = 8;
    localparam int JUMP      = 9;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    // A load is an instruction that writes the register file from memory.
    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[MEMTOREG] & ctrl[REGWRITE];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DW     = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [DW-1:0]     rd1_d,
    input  logic [DW-1:0]     rd2_d,
    input  logic [4:0]        rs_d,
    input  logic [4:0]        rt_d,
    input  logic [4:0]        rd_d,
    input  logic [DW-1:0]     imm_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              flush_e,
    input  logic              hold_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              valid_e,
    output logic [DW-1:0]     rd1_e,
    output logic [DW-1:0]     rd2_e,
    output logic [DW-1:0]     imm_e,
    output logic [4:0]        rs_e,
    output logic [4:0]        rt_e,
    output logic [4:0]        rd_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    logic lw_haz;

    // A load in EX whose target is read by decode; $0 is never a real dependency.
    assign lw_haz = valid_e & ctrl_e[MEMTOREG] & ctrl_e[REGWRITE] & (rt_e != 5'd0)
                  & valid_d & ((rt_e == rs_d) | (rt_e == rt_d));

    assign stall_f = lw_haz | hold_e;
    assign stall_d = lw_haz | hold_e;

    // NOTE: every EX register is reset so ctrl_e is never X while valid_e is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e <= 1'b0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm_e   <= '0;
            rs_e    <= '0;
            rt_e    <= '0;
            rd_e    <= '0;
            ctrl_e  <= '0;
        end else if (flush_e || (lw_haz && !hold_e)) begin
            // Bubble: operand fields are held, only validity and control are cleared.
            valid_e <= 1'b0;
            ctrl_e  <= CTRL_W'(BUBBLE_CTRL);
        end else if (!hold_e) begin
            valid_e <= valid_d;
            rd1_e   <= rd1_d;
            rd2_e   <= rd2_d;
            imm_e   <= imm_d;
            rs_e    <= rs_d;
            rt_e    <= rt_d;
            rd_e    <= rd_d;
            ctrl_e  <= valid_d ? ctrl_d : CTRL_W'(BUBBLE_CTRL);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lw_haz & ~hold_e & ~flush_e),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_e & valid_d),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/reset cases plus a
// randomized run against a slot-level reference model; a CNT_W=4 copy exercises saturation.
module tb_id_ex_stage;

    import pipe_pkg::*;

    localparam int DW = 32;
    localparam logic [9:0] LW_CTRL  = 10'b0000001011;
    localparam logic [9:0] ADD_CTRL = 10'b0010010001;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
        logic [31:0] rd1, rd2, imm;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_d = 1'b0, flush_e = 1'b0, hold_e = 1'b0;
    logic [DW-1:0] rd1_d = '0, rd2_d = '0, imm_d = '0;
    logic [4:0] rs_d = '0, rt_d = '0, rd_d = '0;
    logic [9:0] ctrl_d = '0;

    logic stall_f, stall_d, valid_e;
    logic [DW-1:0] rd1_e, rd2_e, imm_e;
    logic [4:0] rs_e, rt_e, rd_e;
    logic [9:0] ctrl_e;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_stall_f, s_stall_d, s_valid_e;
    logic [DW-1:0] s_rd1_e, s_rd2_e, s_imm_e;
    logic [4:0] s_rs_e, s_rt_e, s_rd_e;
    logic [9:0] s_ctrl_e;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    slot_t m;
    int unsigned n_stall, n_flush;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CTRL_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .flush_e(flush_e), .hold_e(hold_e), .stall_f(stall_f), .stall_d(stall_d),
        .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .ctrl_e(ctrl_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.DW(DW), .CTRL_W(10), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .flush_e(flush_e), .hold_e(hold_e), .stall_f(s_stall_f), .stall_d(s_stall_d),
        .valid_e(s_valid_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .imm_e(s_imm_e),
        .rs_e(s_rs_e), .rt_e(s_rt_e), .rd_e(s_rd_e), .ctrl_e(s_ctrl_e),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_haz();
        return m.v && m.ctrl[MEMTOREG] && m.ctrl[REGWRITE] && (m.rt != 0) && valid_d
               && ((m.rt == rs_d) || (m.rt == rt_d));
    endfunction

    function automatic logic [63:0] sat(input int unsigned n, input int unsigned max);
        return (n > max) ? 64'(max) : 64'(n);
    endfunction

    task automatic model_reset();
        m = '0;
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic check_all();
        logic haz;
        haz = model_haz() | hold_e;
        check("stall_f", stall_f, haz);
        check("stall_d", stall_d, haz);
        check("valid_e", valid_e, m.v);
        check("ctrl_e", ctrl_e, m.ctrl);
        if (m.v) begin
            check("rd1_e", rd1_e, m.rd1);
            check("rd2_e", rd2_e, m.rd2);
            check("imm_e", imm_e, m.imm);
            check("regs_e", {rs_e, rt_e, rd_e}, {m.rs, m.rt, m.rd});
            check("s_data_e", {s_rd1_e, s_rd2_e, s_imm_e, s_rs_e, s_rt_e, s_rd_e} ==
                  {rd1_e, rd2_e, imm_e, rs_e, rt_e, rd_e}, 1'b1);
        end
        check("stall_cnt", stall_cnt, sat(n_stall, 65535));
        check("flush_cnt", flush_cnt, sat(n_flush, 65535));
        check("s_stall_cnt", s_stall_cnt, sat(n_stall, 15));
        check("s_flush_cnt", s_flush_cnt, sat(n_flush, 15));
        check("s_ctl", {s_stall_f, s_stall_d, s_valid_e, s_ctrl_e}, {haz, haz, m.v, m.ctrl});
    endtask

    // One clock: compare at negedge, then advance the model by the posedge rules.
    task automatic step();
        logic haz;
        @(negedge clk);
        check_all();
        haz = model_haz();
        if (haz && !hold_e && !flush_e) n_stall++;
        if (flush_e && valid_d) n_flush++;
        if (flush_e || (haz && !hold_e)) begin
            m.v = 1'b0;
            m.ctrl = '0;
        end else if (!hold_e) begin
            m = '{valid_d, rs_d, rt_d, rd_d, valid_d ? ctrl_d : 10'd0, rd1_d, rd2_d, imm_d};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [9:0] ctrl);
        valid_d = v;
        rs_d = rs;
        rt_d = rt;
        rd_d = rd;
        ctrl_d = ctrl;
        rd1_d = $urandom;
        rd2_d = $urandom;
        imm_d = $urandom;
    endtask

    initial begin
        logic [31:0] saved_rd1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_valid_e", valid_e, 1'b0);
        check("rst_ctrl_e", ctrl_e, 10'd0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
        rst_n = 1'b1;

        // Load-use: lw $5 then add using $5 costs exactly one bubble.
        set_in(1'b1, 5'd1, 5'd5, 5'd0, LW_CTRL);
        step();
        set_in(1'b1, 5'd5, 5'd6, 5'd7, ADD_CTRL);
        check("t2_stall_f", stall_f, 1'b1);
        check("t2_stall_d", stall_d, 1'b1);
        step();
        check("t2_bubble", valid_e, 1'b0);
        check("t2_stall_cnt", stall_cnt, 16'd1);
        check("t2_unstall", stall_f, 1'b0);
        step();
        check("t2_add_in_ex", {valid_e, rs_e}, {1'b1, 5'd5});

        // A load targeting $0 never stalls a reader of $0.
        set_in(1'b1, 5'd2, 5'd0, 5'd0, LW_CTRL);
        step();
        set_in(1'b1, 5'd0, 5'd0, 5'd3, ADD_CTRL);
        check("t3_no_stall", stall_f, 1'b0);
        step();
        check("t3_valid_e", valid_e, 1'b1);
        check("t3_stall_cnt", stall_cnt, 16'd1);

        // Flush on the hazard cycle wins over the bubble and is counted as a flush.
        do_reset();
        set_in(1'b1, 5'd1, 5'd5, 5'd0, LW_CTRL);
        step();
        set_in(1'b1, 5'd5, 5'd6, 5'd7, ADD_CTRL);
        flush_e = 1'b1;
        step();
        flush_e = 1'b0;
        check("t4_valid_e", valid_e, 1'b0);
        check("t4_cnts", {stall_cnt, flush_cnt}, {16'd0, 16'd1});

        // Hold freezes EX while decode inputs change.
        set_in(1'b1, 5'd8, 5'd9, 5'd10, ADD_CTRL);
        step();
        saved_rd1 = rd1_e;
        hold_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd1_d = $urandom;
            #1;
            check("t5_stall_f", stall_f, 1'b1);
            step();
            check("t5_frozen", {valid_e, ctrl_e, rd1_e}, {1'b1, ADD_CTRL, saved_rd1});
            check("t5_cnts", {stall_cnt, flush_cnt}, {16'd0, 16'd1});
        end
        hold_e = 1'b0;

        // Twenty bubbles: the 4-bit counter pins at 15, the 16-bit one reads 20.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 5'd1, 5'd4, 5'd0, LW_CTRL);
            step();
            set_in(1'b1, 5'd2, 5'd4, 5'd3, ADD_CTRL);
            step();
            step();
        end
        check("t6_sat", s_stall_cnt, 4'd15);
        check("t6_wide", stall_cnt, 16'd20);

        // Randomized traffic with narrow register ranges so hazards are frequent.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom), 10'($urandom));
            flush_e = ($urandom_range(0, 9) == 0);
            hold_e  = ($urandom_range(0, 6) == 0);
            step();
        end
        flush_e = 1'b0;
        hold_e = 1'b0;

        // Asynchronous reset while a load-use stall is being signalled.
        set_in(1'b1, 5'd1, 5'd5, 5'd0, LW_CTRL);
        step();
        set_in(1'b1, 5'd5, 5'd5, 5'd7, ADD_CTRL);
        #2;
        check("t1_pre_stall", stall_f, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t1_valid_e", valid_e, 1'b0);
        check("t1_ctrl_e", ctrl_e, 10'd0);
        check("t1_cnts", {stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt}, 40'd0);
        check("t1_stall_drop", stall_f, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("t1_restart", {valid_e, rs_e}, {1'b1, 5'd5});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
